// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control unit: instruction decode, LOAD/STORE sequencing with a
// req/ack handshake and timeout, and flush-slot insertion. Optional perf counters: CTRL_PERF_EN.
module ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
`ifdef CTRL_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             b,
    input  logic             mem_ack,
    output logic [2:0]       imm_type,
    output logic             alu1_sel,
    output logic             alu2_sel,
    output logic [3:0]       alu_op,
    output logic [2:0]       cmp_op,
    output logic [1:0]       rd_sel,
    output logic [1:0]       pc_sel,
    output logic             mem_sel,
    output logic             reg_wr,
    output logic             we,
    output logic             mem_req,
    output logic             bus_err,
    output logic             nop,
    output logic [1:0]       state
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [2:0] IMM_I       = 3'd0;
    localparam logic [2:0] IMM_U       = 3'd1;
    localparam logic [2:0] IMM_J       = 3'd2;
    localparam logic [2:0] IMM_B       = 3'd3;
    localparam logic [2:0] IMM_S       = 3'd4;
    localparam logic [2:0] IMM_DEFAULT = 3'd5;

    localparam logic ALU1_RS  = 1'b0;
    localparam logic ALU1_PC  = 1'b1;
    localparam logic ALU2_IMM = 1'b0;
    localparam logic ALU2_RS  = 1'b1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] CMP_NE  = 3'd1;
    localparam logic [2:0] CMP_LT  = 3'd2;
    localparam logic [2:0] CMP_GE  = 3'd3;
    localparam logic [2:0] CMP_LTU = 3'd4;
    localparam logic [2:0] CMP_GEU = 3'd5;

    localparam logic [1:0] RD_ALU  = 2'd0;
    localparam logic [1:0] RD_IMM  = 2'd1;
    localparam logic [1:0] RD_PCP4 = 2'd2;
    localparam logic [1:0] RD_MEM  = 2'd3;

    localparam logic [1:0] PC_P4  = 2'd0;
    localparam logic [1:0] PC_ALU = 2'd1;
    localparam logic [1:0] PC_OLD = 2'd2;

    localparam logic MEM_PC  = 1'b0;
    localparam logic MEM_ALU = 1'b1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_EXEC    = 2'd0,
        S_LD_WAIT = 2'd1,
        S_LD_WB   = 2'd2,
        S_ST_WAIT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_nop_q;
    logic            w_nop_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_nxt;
    logic            w_timeout;
    logic            w_is_op;
    logic            w_unused_func7;

    assign w_unused_func7 = &{1'b0, func7[6], func7[4:0]};
    assign w_is_op        = (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
    assign w_timeout      = (r_to_cnt == TO_LAST) && !mem_ack;
    assign state          = r_state;

    always_comb begin
        imm_type = IMM_DEFAULT;
        alu1_sel = ALU1_RS;
        alu2_sel = ALU2_IMM;
        unique case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_type = IMM_I;
            OPC_LUI:    imm_type = IMM_U;
            OPC_STORE:  imm_type = IMM_S;
            OPC_JAL: begin
                imm_type = IMM_J;
                alu1_sel = ALU1_PC;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                alu1_sel = ALU1_PC;
            end
            OPC_OP:     alu2_sel = ALU2_RS;
            default: ;
        endcase
    end

    always_comb begin
        unique case (func3)
            3'b001:  cmp_op = CMP_NE;
            3'b100:  cmp_op = CMP_LT;
            3'b101:  cmp_op = CMP_GE;
            3'b110:  cmp_op = CMP_LTU;
            3'b111:  cmp_op = CMP_GEU;
            default: cmp_op = CMP_EQ;
        endcase
    end

    // SUB only exists for register-register ops; OP_IMM with func7[5] set is still ADDI.
    always_comb begin
        alu_op = ALU_ADD;
        if (w_is_op) begin
            unique case (func3)
                3'b000:  alu_op = (opcode == OPC_OP && func7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = func7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_EXEC;
            r_nop_q  <= 1'b1;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_nop_q  <= w_nop_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_nop_nxt   = 1'b0;
        w_to_nxt    = '0;
        reg_wr      = 1'b0;
        we          = 1'b0;
        mem_req     = 1'b0;
        bus_err     = 1'b0;
        nop         = 1'b0;
        pc_sel      = PC_P4;
        mem_sel     = MEM_PC;
        rd_sel      = (opcode == OPC_LUI) ? RD_IMM : RD_ALU;

        unique case (r_state)
            S_EXEC: begin
                if (r_nop_q) begin
                    nop = 1'b1;
                end else begin
                    unique case (opcode)
                        OPC_OP, OPC_OP_IMM, OPC_LUI: reg_wr = 1'b1;
                        OPC_JAL, OPC_JALR: begin
                            reg_wr    = 1'b1;
                            rd_sel    = RD_PCP4;
                            pc_sel    = PC_ALU;
                            w_nop_nxt = 1'b1;
                        end
                        OPC_BRANCH: begin
                            if (b) begin
                                pc_sel    = PC_ALU;
                                w_nop_nxt = 1'b1;
                            end
                        end
                        OPC_LOAD: begin
                            mem_req     = 1'b1;
                            mem_sel     = MEM_ALU;
                            pc_sel      = PC_OLD;
                            w_state_nxt = S_LD_WAIT;
                        end
                        OPC_STORE: begin
                            mem_req     = 1'b1;
                            we          = 1'b1;
                            mem_sel     = MEM_ALU;
                            pc_sel      = PC_OLD;
                            w_state_nxt = S_ST_WAIT;
                        end
                        default: nop = 1'b1;
                    endcase
                end
            end
            S_LD_WAIT: begin
                mem_req = 1'b1;
                mem_sel = MEM_ALU;
                pc_sel  = PC_OLD;
                if (mem_ack) begin
                    w_state_nxt = S_LD_WB;
                end else if (w_timeout) begin
                    bus_err     = 1'b1;
                    pc_sel      = PC_P4;
                    w_state_nxt = S_EXEC;
                    w_nop_nxt   = 1'b1;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            S_LD_WB: begin
                reg_wr      = 1'b1;
                rd_sel      = RD_MEM;
                w_state_nxt = S_EXEC;
                w_nop_nxt   = 1'b1;
            end
            default: begin
                mem_req = 1'b1;
                we      = 1'b1;
                mem_sel = MEM_ALU;
                pc_sel  = PC_OLD;
                if (mem_ack || w_timeout) begin
                    bus_err     = !mem_ack;
                    pc_sel      = PC_P4;
                    w_state_nxt = S_EXEC;
                    w_nop_nxt   = 1'b1;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
        endcase

        // Reset must kill any side effect in the very cycle it is asserted.
        if (rst) begin
            reg_wr  = 1'b0;
            we      = 1'b0;
            mem_req = 1'b0;
            bus_err = 1'b0;
            pc_sel  = PC_P4;
        end
    end

`ifdef CTRL_PERF_EN
    logic             w_retire;
    logic             w_stall;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_stall  = (r_state == S_LD_WAIT) || (r_state == S_ST_WAIT);
    assign w_retire = (r_state == S_LD_WB)
                   || (r_state == S_ST_WAIT && mem_ack)
                   || (r_state == S_EXEC && !r_nop_q &&
                       (w_is_op || opcode == OPC_LUI || opcode == OPC_JAL ||
                        opcode == OPC_JALR || opcode == OPC_BRANCH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_retire)
                r_ret_cnt <= r_ret_cnt + 1'b1;
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign ret_cnt   = r_ret_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed-vector bench for ctrl_fsm: decode, flush slots, LOAD/STORE handshake,
// timeout and reset-abort, checked with immediate assertions.
module tb_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic       mem_ack;
    logic [2:0] imm_type;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] rd_sel;
    logic [1:0] pc_sel;
    logic       mem_sel;
    logic       reg_wr;
    logic       we;
    logic       mem_req;
    logic       bus_err;
    logic       nop;
    logic [1:0] state;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] OP     = 5'b01100;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JAL    = 5'b11011;

    ctrl_fsm #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .b(b), .mem_ack(mem_ack), .imm_type(imm_type), .alu1_sel(alu1_sel),
        .alu2_sel(alu2_sel), .alu_op(alu_op), .cmp_op(cmp_op), .rd_sel(rd_sel),
        .pc_sel(pc_sel), .mem_sel(mem_sel), .reg_wr(reg_wr), .we(we),
        .mem_req(mem_req), .bus_err(bus_err), .nop(nop), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_cycles;
        rst = 1'b1; opcode = OP_IMM; func3 = 3'b000; func7 = 7'b0; b = 1'b0; mem_ack = 1'b0;

        next();
        settle();
        chk("rst_state", 32'(state), 0);
        chk("rst_nop", 32'(nop), 1);
        chk("rst_reg_wr", 32'(reg_wr), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_pc_sel", 32'(pc_sel), 0);
        next();
        rst = 1'b0;

        settle();
        chk("first_nop", 32'(nop), 1);
        chk("first_reg_wr", 32'(reg_wr), 0);
        next();
        settle();
        chk("opimm_reg_wr", 32'(reg_wr), 1);
        chk("opimm_pc_sel", 32'(pc_sel), 0);
        chk("opimm_nop", 32'(nop), 0);
        chk("opimm_imm", 32'(imm_type), 0);
        next();

        opcode = OP; func3 = 3'b000; func7 = 7'b0100000;
        settle();
        chk("op_sub", 32'(alu_op), 1);
        chk("op_alu2", 32'(alu2_sel), 1);
        next();
        opcode = OP_IMM;
        settle();
        chk("opimm_add", 32'(alu_op), 0);
        chk("opimm_alu2", 32'(alu2_sel), 0);
        next();
        func3 = 3'b101;
        settle();
        chk("opimm_sra", 32'(alu_op), 7);
        next();
        opcode = OP; func7 = 7'b0;
        settle();
        chk("op_srl", 32'(alu_op), 6);
        next();
        func3 = 3'b111;
        settle();
        chk("op_and", 32'(alu_op), 9);
        next();

        opcode = BRANCH; func3 = 3'b110; b = 1'b1;
        settle();
        chk("br_t_pc", 32'(pc_sel), 1);
        chk("br_t_alu1", 32'(alu1_sel), 1);
        chk("br_t_imm", 32'(imm_type), 3);
        chk("br_cmp_ltu", 32'(cmp_op), 4);
        chk("br_t_alu_op", 32'(alu_op), 0);
        next();
        opcode = OP; func3 = 3'b000; b = 1'b0;
        settle();
        chk("br_t_flush", 32'(nop), 1);
        chk("br_t_flush_wr", 32'(reg_wr), 0);
        next();
        opcode = BRANCH;
        settle();
        chk("br_nt_pc", 32'(pc_sel), 0);
        next();
        opcode = OP;
        settle();
        chk("br_nt_nop", 32'(nop), 0);
        chk("br_nt_next_wr", 32'(reg_wr), 1);
        next();

        opcode = JAL;
        settle();
        chk("jal_wr", 32'(reg_wr), 1);
        chk("jal_rd", 32'(rd_sel), 2);
        chk("jal_pc", 32'(pc_sel), 1);
        chk("jal_imm", 32'(imm_type), 2);
        next();
        opcode = OP;
        settle();
        chk("jal_flush", 32'(nop), 1);
        next();

        // LOAD with ack in the second LD_WAIT cycle: state 0,1,1,2,0
        opcode = LOAD;
        settle();
        chk("ld_exec_state", 32'(state), 0);
        chk("ld_exec_req", 32'(mem_req), 1);
        chk("ld_exec_pc", 32'(pc_sel), 2);
        chk("ld_exec_msel", 32'(mem_sel), 1);
        chk("ld_exec_wr", 32'(reg_wr), 0);
        next();
        settle();
        chk("ld_w1_state", 32'(state), 1);
        chk("ld_w1_req", 32'(mem_req), 1);
        chk("ld_w1_wr", 32'(reg_wr), 0);
        next();
        mem_ack = 1'b1;
        settle();
        chk("ld_w2_state", 32'(state), 1);
        chk("ld_w2_wr", 32'(reg_wr), 0);
        next();
        mem_ack = 1'b0;
        settle();
        chk("ld_wb_state", 32'(state), 2);
        chk("ld_wb_wr", 32'(reg_wr), 1);
        chk("ld_wb_rd", 32'(rd_sel), 3);
        chk("ld_wb_msel", 32'(mem_sel), 0);
        chk("ld_wb_pc", 32'(pc_sel), 0);
        next();
        opcode = OP;
        settle();
        chk("ld_after_state", 32'(state), 0);
        chk("ld_after_nop", 32'(nop), 1);
        chk("ld_after_wr", 32'(reg_wr), 0);
        next();

        // STORE with no ack: 1 EXEC + 16 ST_WAIT cycles with we=1, bus_err on the last
        opcode = STORE;
        we_cycles = 0;
        settle();
        chk("st_exec_state", 32'(state), 0);
        if (we) we_cycles++;
        next();
        for (int i = 1; i <= 16; i++) begin
            settle();
            chk($sformatf("st_w%0d_state", i), 32'(state), 3);
            chk($sformatf("st_w%0d_bus_err", i), 32'(bus_err), (i == 16) ? 1 : 0);
            chk($sformatf("st_w%0d_pc", i), 32'(pc_sel), (i == 16) ? 0 : 2);
            if (we) we_cycles++;
            next();
        end
        opcode = OP;
        settle();
        chk("st_to_state", 32'(state), 0);
        chk("st_to_nop", 32'(nop), 1);
        chk("st_to_we", 32'(we), 0);
        chk("st_we_cycles", 32'(we_cycles), 17);
        next();

        // LOAD with ack coinciding with the timeout cycle: ack wins
        opcode = LOAD;
        next();
        for (int i = 1; i <= 15; i++) next();
        mem_ack = 1'b1;
        settle();
        chk("ld_race_state", 32'(state), 1);
        chk("ld_race_bus_err", 32'(bus_err), 0);
        next();
        mem_ack = 1'b0;
        opcode = OP;
        settle();
        chk("ld_race_wb", 32'(state), 2);
        chk("ld_race_wb_wr", 32'(reg_wr), 1);
        next();
        settle();
        chk("ld_race_flush", 32'(nop), 1);
        next();

        // Reset in LD_WAIT aborts the access immediately
        opcode = LOAD;
        next();
        settle();
        chk("rw_wait_state", 32'(state), 1);
        chk("rw_wait_req", 32'(mem_req), 1);
        next();
        rst = 1'b1;
        settle();
        chk("rw_rst_req", 32'(mem_req), 0);
        chk("rw_rst_pc", 32'(pc_sel), 0);
        next();
        rst = 1'b0; mem_ack = 1'b1;
        settle();
        chk("rw_after_state", 32'(state), 0);
        chk("rw_after_nop", 32'(nop), 1);
        chk("rw_late_ack_wr", 32'(reg_wr), 0);
        next();
        mem_ack = 1'b0; opcode = OP;
        settle();
        chk("rw_resume_state", 32'(state), 0);
        chk("rw_resume_wr", 32'(reg_wr), 1);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
